// File: rtl/nios_system_pio_bank.sv
// Bidirectional Avalon-MM PIO bank: direction control, set/clear writes,
// synchronised inputs, edge capture and a maskable level interrupt.
module nios_system_pio_bank #(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    EDGE_TYPE   = 0,
   parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] oe,
   output logic                  irq
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_DIR    = 3'd1;
   localparam logic [2:0] A_MASK   = 3'd2;
   localparam logic [2:0] A_EDGE   = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;

   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_dir;
   logic [DATA_WIDTH-1:0] r_mask;
   logic [DATA_WIDTH-1:0] r_cap;
   logic [DATA_WIDTH-1:0] r_sync1;
   logic [DATA_WIDTH-1:0] r_sync2;
   logic [DATA_WIDTH-1:0] r_prev;
   logic                  r_irq;
   logic [31:0]           r_rd;

   logic                  w_wr;
   logic [DATA_WIDTH-1:0] w_wd;
   logic [DATA_WIDTH-1:0] w_rise;
   logic [DATA_WIDTH-1:0] w_fall;
   logic [DATA_WIDTH-1:0] w_edge;
   logic [DATA_WIDTH-1:0] w_clr;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic [DATA_WIDTH-1:0] w_rdmux;
   logic [31:0]           w_rd32;
   logic                  w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_wd     = writedata[DATA_WIDTH-1:0];
   assign w_unused = ^writedata;

   assign w_rise = r_sync2 & ~r_prev;
   assign w_fall = ~r_sync2 & r_prev;

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign w_edge = w_rise;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign w_edge = w_fall;
      end else begin : g_any
         assign w_edge = w_rise | w_fall;
      end
   endgenerate

   // A same-cycle edge overrides the clear so no event is lost
   assign w_clr = (w_wr && address == A_EDGE) ? w_wd : '0;

   always_comb begin
      w_data_nxt = r_data;
      if (w_wr) begin
         case (address)
            A_DATA:   w_data_nxt = w_wd;
            A_OUTSET: w_data_nxt = r_data | w_wd;
            A_OUTCLR: w_data_nxt = r_data & ~w_wd;
            default:  w_data_nxt = r_data;
         endcase
      end
   end

   always_comb begin
      w_rdmux = '0;
      case (address)
         A_DATA:  w_rdmux = (r_sync2 & ~r_dir) | (r_data & r_dir);
         A_DIR:   w_rdmux = r_dir;
         A_MASK:  w_rdmux = r_mask;
         A_EDGE:  w_rdmux = r_cap;
         default: w_rdmux = '0;
      endcase
   end

   always_comb begin
      w_rd32 = '0;
      w_rd32[DATA_WIDTH-1:0] = w_rdmux;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= RESET_VALUE;
         r_dir   <= DIR_RESET;
         r_mask  <= '0;
         r_cap   <= '0;
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_irq   <= 1'b0;
         r_rd    <= '0;
      end else begin
         r_data  <= w_data_nxt;
         if (w_wr && address == A_DIR) r_dir <= w_wd;
         if (w_wr && address == A_MASK) r_mask <= w_wd;
         r_cap   <= (r_cap & ~w_clr) | w_edge;
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_irq   <= |(r_cap & r_mask);
         r_rd    <= w_rd32;
      end
   end

   assign readdata = r_rd;
   assign out_port = r_data;
   assign oe       = r_dir;
   assign irq      = r_irq;

endmodule

// File: tb/tb_nios_system_pio_bank.sv
// Bench for nios_system_pio_bank: directed table, corner sequences and
// random traffic against a pin-history reference model, all edge types.
module tb_nios_system_pio_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [15:0] in_port;

   logic [31:0] rd  [3];
   logic [15:0] op  [3];
   logic [15:0] oe  [3];
   logic        irq [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nios_system_pio_bank #(
      .DATA_WIDTH(16), .RESET_VALUE(16'hA5A5),
      .EDGE_TYPE(0), .DIR_RESET(16'hFFFF)
   ) u_rise (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd[0]), .in_port(in_port),
      .out_port(op[0]), .oe(oe[0]), .irq(irq[0])
   );

   nios_system_pio_bank #(
      .DATA_WIDTH(16), .RESET_VALUE(16'hA5A5),
      .EDGE_TYPE(1), .DIR_RESET(16'hFFFF)
   ) u_fall (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd[1]), .in_port(in_port),
      .out_port(op[1]), .oe(oe[1]), .irq(irq[1])
   );

   nios_system_pio_bank #(
      .DATA_WIDTH(16), .RESET_VALUE(16'hA5A5),
      .EDGE_TYPE(2), .DIR_RESET(16'hFFFF)
   ) u_any (
      .clk(clk), .reset(reset), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(rd[2]), .in_port(in_port),
      .out_port(op[2]), .oe(oe[2]), .irq(irq[2])
   );

   // Reference model: pins seen 1, 2 and 3 clock edges ago
   logic [15:0] h1, h2, h3;
   logic [15:0] m_data [3];
   logic [15:0] m_dir  [3];
   logic [15:0] m_mask [3];
   logic [15:0] m_cap  [3];
   logic        m_irq  [3];
   logic [31:0] m_rd   [3];
   logic        m_wr;
   logic [15:0] m_wd, m_rise, m_fall, m_ev, m_clr, m_rv;
   logic        m_irqn;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            m_data[i] = 16'hA5A5;
            m_dir[i]  = 16'hFFFF;
            m_mask[i] = '0;
            m_cap[i]  = '0;
            m_irq[i]  = 1'b0;
            m_rd[i]   = '0;
         end
         h1 = '0; h2 = '0; h3 = '0;
      end else begin
         m_wr   = chipselect & ~write_n;
         m_wd   = writedata[15:0];
         m_rise = h2 & ~h3;
         m_fall = ~h2 & h3;
         for (int i = 0; i < 3; i++) begin
            m_ev = (i == 0) ? m_rise : (i == 1) ? m_fall : (m_rise | m_fall);
            case (address)
               3'd0:    m_rv = (h2 & ~m_dir[i]) | (m_data[i] & m_dir[i]);
               3'd1:    m_rv = m_dir[i];
               3'd2:    m_rv = m_mask[i];
               3'd3:    m_rv = m_cap[i];
               default: m_rv = '0;
            endcase
            m_irqn = (m_cap[i] & m_mask[i]) != 0;
            m_clr  = (m_wr && address == 3'd3) ? m_wd : 16'h0;
            m_cap[i] = (m_cap[i] & ~m_clr) | m_ev;
            m_irq[i] = m_irqn;
            m_rd[i]  = {16'h0, m_rv};
            if (m_wr) begin
               case (address)
                  3'd0: m_data[i] = m_wd;
                  3'd1: m_dir[i]  = m_wd;
                  3'd2: m_mask[i] = m_wd;
                  3'd4: m_data[i] = m_data[i] | m_wd;
                  3'd5: m_data[i] = m_data[i] & ~m_wd;
                  default: ;
               endcase
            end
         end
         h3 = h2; h2 = h1; h1 = in_port;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic [2:0] a, input logic w,
                      input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = ~w;
      writedata  = d;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0]  a;
      logic        w;
      logic [31:0] d;
      logic [15:0] e_out;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{3'd0, 1'b0, 32'h0,    16'hA5A5, 32'hA5A5};
      tbl[1]  = '{3'd0, 1'b1, 32'h00F0, 16'h00F0, 32'hA5A5};
      tbl[2]  = '{3'd4, 1'b1, 32'h0F00, 16'h0FF0, 32'h0};
      tbl[3]  = '{3'd5, 1'b1, 32'h0030, 16'h0FC0, 32'h0};
      tbl[4]  = '{3'd0, 1'b0, 32'h0,    16'h0FC0, 32'h0FC0};
      tbl[5]  = '{3'd4, 1'b0, 32'h0,    16'h0FC0, 32'h0};
      tbl[6]  = '{3'd5, 1'b0, 32'h0,    16'h0FC0, 32'h0};
      tbl[7]  = '{3'd1, 1'b1, 32'h00FF, 16'h0FC0, 32'hFFFF};
      tbl[8]  = '{3'd1, 1'b0, 32'h0,    16'h0FC0, 32'h00FF};
      tbl[9]  = '{3'd2, 1'b1, 32'h1234, 16'h0FC0, 32'h0};
      tbl[10] = '{3'd2, 1'b0, 32'h0,    16'h0FC0, 32'h1234};
      tbl[11] = '{3'd2, 1'b1, 32'h0,    16'h0FC0, 32'h1234};
      tbl[12] = '{3'd7, 1'b1, 32'hFFFF, 16'h0FC0, 32'h0};
      tbl[13] = '{3'd6, 1'b0, 32'h0,    16'h0FC0, 32'h0};
      tbl[14] = '{3'd0, 1'b1, 32'hFFFF, 16'hFFFF, 32'h00C0};
      tbl[15] = '{3'd0, 1'b0, 32'h0,    16'hFFFF, 32'h00FF};

      reset = 1'b1; address = '0; chipselect = 1'b0;
      write_n = 1'b1; writedata = '0; in_port = '0;
      @(negedge clk);
      cyc();
      chk("rst_out", {16'h0, op[0]}, 32'hA5A5);
      chk("rst_oe", {16'h0, oe[0]}, 32'hFFFF);
      chk("rst_irq", {31'h0, irq[0]}, 32'h0);
      chk("rst_rd", rd[0], 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         bus(tbl[i].a, tbl[i].w, tbl[i].d);
         cyc();
         chk($sformatf("tbl%0d_out", i), {16'h0, op[0]}, {16'h0, tbl[i].e_out});
         chk($sformatf("tbl%0d_rd", i), rd[0], tbl[i].e_rd);
      end

      // mixed direction read and input latency
      bus(3'd0, 1'b0, 32'h0);
      in_port = 16'h1200;
      cyc();
      chk("lat1", rd[0], 32'h00FF);
      cyc();
      chk("lat2", rd[0], 32'h00FF);
      cyc();
      chk("lat3", rd[0], 32'h12FF);
      chk("oe_mix", {16'h0, oe[0]}, 32'h00FF);

      // rising edge on bit0 raises irq, clear drops it
      repeat (3) cyc();
      bus(3'd3, 1'b1, 32'hFFFF); cyc();
      bus(3'd2, 1'b1, 32'h0001); cyc();
      bus(3'd3, 1'b0, 32'h0); cyc();
      chk("cap_clr0", rd[0], 32'h0);
      in_port = 16'h1201;
      cyc(); cyc(); cyc();
      chk("irq_early", {31'h0, irq[0]}, 32'h0);
      cyc();
      chk("irq_set", {31'h0, irq[0]}, 32'h1);
      chk("cap_set", rd[0], 32'h0001);
      bus(3'd3, 1'b1, 32'h0001); cyc();
      chk("irq_hold1", {31'h0, irq[0]}, 32'h1);
      bus(3'd3, 1'b0, 32'h0); cyc();
      chk("irq_clr", {31'h0, irq[0]}, 32'h0);
      chk("cap_clr", rd[0], 32'h0);

      // clear and new edge in the same cycle: edge wins
      in_port = 16'h1200; repeat (4) cyc();
      in_port = 16'h1201; repeat (4) cyc();
      chk("irq_set2", {31'h0, irq[0]}, 32'h1);
      in_port = 16'h1200; repeat (4) cyc();
      in_port = 16'h1201; cyc(); cyc();
      bus(3'd3, 1'b1, 32'h0001); cyc();
      bus(3'd3, 1'b0, 32'h0); cyc();
      chk("cap_wins", rd[0], 32'h0001);
      chk("irq_stay1", {31'h0, irq[0]}, 32'h1);
      cyc();
      chk("irq_stay2", {31'h0, irq[0]}, 32'h1);

      // reset mid-operation
      bus(3'd2, 1'b1, 32'hFFFF); cyc();
      bus(3'd3, 1'b0, 32'h0);
      in_port = 16'h0000; repeat (4) cyc();
      in_port = 16'hFFFF; repeat (5) cyc();
      chk("cap_all", rd[0], 32'hFFFF);
      chk("irq_all", {31'h0, irq[0]}, 32'h1);
      reset = 1'b1; chipselect = 1'b0; in_port = 16'h0000;
      cyc();
      reset = 1'b0;
      chk("mid_rst_out", {16'h0, op[0]}, 32'hA5A5);
      chk("mid_rst_oe", {16'h0, oe[0]}, 32'hFFFF);
      chk("mid_rst_irq", {31'h0, irq[0]}, 32'h0);
      chk("mid_rst_rd", rd[0], 32'h0);
      bus(3'd7, 1'b1, 32'hFFFF_FFFF); cyc();
      bus(3'd0, 1'b0, 32'h0); cyc();
      chk("a7_data", rd[0], 32'hA5A5);
      bus(3'd1, 1'b0, 32'h0); cyc();
      chk("a7_dir", rd[0], 32'hFFFF);
      bus(3'd2, 1'b0, 32'h0); cyc();
      chk("a7_mask", rd[0], 32'h0);
      bus(3'd3, 1'b0, 32'h0); cyc();
      chk("a7_cap", rd[0], 32'h0);
      chk("a7_irq", {31'h0, irq[0]}, 32'h0);

      // random traffic, all three edge types against the model
      for (int n = 0; n < 800; n++) begin
         reset      = ($urandom_range(0, 99) == 0);
         address    = 3'($urandom_range(0, 7));
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = 1'($urandom_range(0, 1));
         writedata  = $urandom;
         if ($urandom_range(0, 2) == 0) in_port = 16'($urandom);
         cyc();
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("rnd%0d_u%0d_out", n, i), {16'h0, op[i]}, {16'h0, m_data[i]});
            chk($sformatf("rnd%0d_u%0d_oe", n, i), {16'h0, oe[i]}, {16'h0, m_dir[i]});
            chk($sformatf("rnd%0d_u%0d_irq", n, i), {31'h0, irq[i]}, {31'h0, m_irq[i]});
            chk($sformatf("rnd%0d_u%0d_rd", n, i), rd[i], m_rd[i]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
